// File: rtl/display_pkg.sv
// Shared constants and symbol codes for the display scan path.
// Symbol codes must stay in step with the binary_to_segment decoder.
package display_pkg;

    localparam int CODE_W     = 5;
    localparam int NUM_DIGITS = 4;

    typedef logic [CODE_W-1:0] symbol_t;

    localparam symbol_t CODE_BLANK = 5'b00000;

    // Decimal digits 0..9 occupy codes 1..10 so that code 0 stays blank.
    localparam symbol_t SYM_0    = 5'h01;
    localparam symbol_t SYM_1    = 5'h02;
    localparam symbol_t SYM_2    = 5'h03;
    localparam symbol_t SYM_3    = 5'h04;
    localparam symbol_t SYM_4    = 5'h05;
    localparam symbol_t SYM_5    = 5'h06;
    localparam symbol_t SYM_6    = 5'h07;
    localparam symbol_t SYM_7    = 5'h08;
    localparam symbol_t SYM_8    = 5'h09;
    localparam symbol_t SYM_9    = 5'h0A;
    localparam symbol_t SYM_DASH = 5'h0B;
    localparam symbol_t SYM_L    = 5'h0C;
    localparam symbol_t SYM_D    = 5'h0D;
    localparam symbol_t SYM_P    = 5'h0E;
    localparam symbol_t SYM_N    = 5'h0F;

    function automatic symbol_t digit_code(input logic [3:0] value);
        return symbol_t'(value) + SYM_0;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter that emits a one-cycle tick on its last count.
// The count only advances (and tick only fires) while en is high.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit time-multiplexed symbol scanner with a double-buffered display word.
// Optional per-digit blinking is compiled in when BLINK_EN is defined.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
`ifdef BLINK_EN
    ,
    parameter int BLINK_FRAMES = 250
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_in,
    input  logic [NUM_DIGITS*CODE_W-1:0] display_in,
    input  logic                       load_in,
    output logic                       busy_out,
    output logic [CODE_W-1:0]          binary_out,
    output logic [NUM_DIGITS-1:0]      anode_out,
`ifdef BLINK_EN
    input  logic [NUM_DIGITS-1:0]      blink_mask_in,
`endif
    output logic                       frame_out
);

    // Interface: load_in is a fire-and-forget strobe (no ready). busy_out is a
    // status flag that stays high from the cycle after a load until the pending
    // word has been copied into the displayed word at a frame boundary.

    logic                    slot_tick;
    logic                    frame_tick;
    logic                    apply;
    logic                    blank_digit;
    logic [1:0]              index;
    symbol_t [NUM_DIGITS-1:0] active_q;
    symbol_t [NUM_DIGITS-1:0] pending_q;
    logic                    busy_q;

    tick_divider #(.DIV(REFRESH_DIV)) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .en   (enable_in),
        .tick (slot_tick)
    );

    assign frame_tick = slot_tick && (index == 2'(NUM_DIGITS - 1));
    assign apply      = frame_tick && busy_q;
    assign busy_out   = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            index <= 2'd0;
        end else if (slot_tick) begin
            index <= index + 2'd1;
        end
    end

    // The displayed word only changes on a frame boundary so a frame never mixes words.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= '0;
            pending_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (apply) begin
                active_q <= pending_q;
            end
            if (load_in) begin
                pending_q <= display_in;
                busy_q    <= 1'b1;
            end else if (apply) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef BLINK_EN
    logic blink_wrap;
    logic blink_phase;

    tick_divider #(.DIV(BLINK_FRAMES)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .en   (frame_tick),
        .tick (blink_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_phase <= ~blink_phase;
        end
    end

    assign blank_digit = blink_phase && blink_mask_in[index];
`else
    assign blank_digit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_out  <= 4'b1110;
            binary_out <= CODE_BLANK;
            frame_out  <= 1'b0;
        end else begin
            frame_out <= frame_tick;
            if (enable_in) begin
                anode_out  <= ~(4'b0001 << index);
                binary_out <= blank_digit ? CODE_BLANK : active_q[index];
            end else begin
                anode_out  <= 4'b1111;
                binary_out <= CODE_BLANK;
            end
        end
    end

endmodule
